// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU and its arbiter:
//   - default operand/result width and function-code width
//   - ALU function-code constants (RISC-V style funct7[5]:funct3 encoding)
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH  = 32;
    localparam int ALU_FUNC_W = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

endpackage

// File: rtl/alu_arbiter_if.sv
// ---------------------------------------------------------------------------
// alu_arbiter_if
// One requester's connection to the ALU arbiter: a valid/ready request
// channel (two operands + function code) and a valid/ready response channel.
//   master : requester side (drives request, consumes response)
//   slave  : arbiter side   (accepts request, produces response)
// ---------------------------------------------------------------------------
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int FUNC_W = ALU_FUNC_W
);
    logic              req_valid;
    logic              req_ready;
    logic [WIDTH-1:0]  req_in0;
    logic [WIDTH-1:0]  req_in1;
    logic [FUNC_W-1:0] req_func;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WIDTH-1:0]  rsp_out;

    modport master (
        output req_valid, req_in0, req_in1, req_func, rsp_ready,
        input  req_ready, rsp_valid, rsp_out
    );

    modport slave (
        input  req_valid, req_in0, req_in1, req_func, rsp_ready,
        output req_ready, rsp_valid, rsp_out
    );
endinterface

// File: rtl/alu_rsp_slot.sv
// ---------------------------------------------------------------------------
// alu_rsp_slot
// One-entry registered response buffer.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          capture din this cycle (arbiter granted this requester)
//   din           ALU result to capture
//   rsp_ready     consumer takes the current entry
//   rsp_valid     entry holds a result
//   rsp_out       the held result
//   free          slot can accept a load this cycle (empty or being drained)
// ---------------------------------------------------------------------------
module alu_rsp_slot #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             rsp_ready,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_out,
    output logic             free
);

    logic             valid_r;
    logic [WIDTH-1:0] data_r;

    // A load wins over a drain so a same-cycle drain+grant keeps valid high.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= din;
        end else if (rsp_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign rsp_valid = valid_r;
    assign rsp_out   = data_r;
    assign free      = ~valid_r | rsp_ready;

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters with round-robin
// arbitration and a one-entry registered response slot per requester.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   p0, p1            requester channels (alu_arbiter_if.slave)
//   alu_in0/alu_in1   operands to the ALU (zero when idle)
//   alu_func          function code to the ALU (ADD when idle)
//   alu_out           combinational ALU result
// Optional build macro ALU_ARB_STATS_EN adds saturating 32-bit counters
//   grant_cnt0, grant_cnt1 (grants per requester) and conflict_cnt
//   (cycles with both requesters eligible).
// ---------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int FUNC_W = ALU_FUNC_W
) (
    input  logic              clk,
    input  logic              rst,
    alu_arbiter_if.slave      p0,
    alu_arbiter_if.slave      p1,
    output logic [WIDTH-1:0]  alu_in0,
    output logic [WIDTH-1:0]  alu_in1,
    output logic [FUNC_W-1:0] alu_func,
`ifdef ALU_ARB_STATS_EN
    output logic [31:0]       grant_cnt0,
    output logic [31:0]       grant_cnt1,
    output logic [31:0]       conflict_cnt,
`endif
    input  logic [WIDTH-1:0]  alu_out
);

    logic free0_s, free1_s;
    logic elig0_s, elig1_s, both_s;
    logic grant0_s, grant1_s;
    logic ptr_r;    // 0: requester 0 has priority, 1: requester 1

    // Eligibility and grant; nothing is granted while reset is asserted.
    always_comb begin
        elig0_s  = p0.req_valid & free0_s;
        elig1_s  = p1.req_valid & free1_s;
        both_s   = elig0_s & elig1_s;
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (both_s) begin
            grant0_s = ~ptr_r;
            grant1_s = ptr_r;
        end else begin
            grant0_s = elig0_s;
            grant1_s = elig1_s;
        end
    end

    assign p0.req_ready = grant0_s;
    assign p1.req_ready = grant1_s;

    // Priority pointer: hand priority to the loser of a contended grant only.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r <= 1'b0;
        end else if (both_s) begin
            ptr_r <= grant0_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // ALU operand mux: granted request's fields, zeros/ADD when idle.
    always_comb begin
        alu_in0  = '0;
        alu_in1  = '0;
        alu_func = FUNC_W'(ALU_ADD);
        if (grant0_s) begin
            alu_in0  = p0.req_in0;
            alu_in1  = p0.req_in1;
            alu_func = p0.req_func;
        end else if (grant1_s) begin
            alu_in0  = p1.req_in0;
            alu_in1  = p1.req_in1;
            alu_func = p1.req_func;
        end else begin
            alu_in0  = '0;
            alu_in1  = '0;
            alu_func = FUNC_W'(ALU_ADD);
        end
    end

    alu_rsp_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (grant0_s),
        .din       (alu_out),
        .rsp_ready (p0.rsp_ready),
        .rsp_valid (p0.rsp_valid),
        .rsp_out   (p0.rsp_out),
        .free      (free0_s)
    );

    alu_rsp_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (grant1_s),
        .din       (alu_out),
        .rsp_ready (p1.rsp_ready),
        .rsp_valid (p1.rsp_valid),
        .rsp_out   (p1.rsp_out),
        .free      (free1_s)
    );

`ifdef ALU_ARB_STATS_EN
    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    logic [31:0] grant_cnt0_r, grant_cnt1_r, conflict_cnt_r;

    // Saturating grant/conflict counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0_r   <= 32'd0;
            grant_cnt1_r   <= 32'd0;
            conflict_cnt_r <= 32'd0;
        end else begin
            if (grant0_s && (grant_cnt0_r != CNT_MAX)) begin
                grant_cnt0_r <= grant_cnt0_r + 32'd1;
            end else begin
                grant_cnt0_r <= grant_cnt0_r;
            end
            if (grant1_s && (grant_cnt1_r != CNT_MAX)) begin
                grant_cnt1_r <= grant_cnt1_r + 32'd1;
            end else begin
                grant_cnt1_r <= grant_cnt1_r;
            end
            if (both_s && (conflict_cnt_r != CNT_MAX)) begin
                conflict_cnt_r <= conflict_cnt_r + 32'd1;
            end else begin
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    assign grant_cnt0   = grant_cnt0_r;
    assign grant_cnt1   = grant_cnt1_r;
    assign conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU between two requesters, e.g. the integer pipe and the address/branch unit.
- Arbitration is round-robin with a valid/ready request interface.
- Each requester has a one-entry registered response slot with its own valid/ready handshake.
- The block drives the ALU's two operands and 4-bit function code, and captures the ALU result.

Parameters:
WIDTH, 32, operand/result width
FUNC_W, 4, ALU function code width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_in0  in  WIDTH  operand A
req0_in1  in  WIDTH  operand B
req0_func  in  FUNC_W  ALU function code
rsp0_valid  out  1  result available for requester 0
rsp0_ready  in  1  requester 0 consumes its result
rsp0_out  out  WIDTH  result for requester 0
req1_*, rsp1_*  same set as requester 0, for requester 1
alu_in0  out  WIDTH  to ALU operand A
alu_in1  out  WIDTH  to ALU operand B
alu_func  out  FUNC_W  to ALU function code
alu_out  in  WIDTH  from ALU, combinational result

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - On reset: rsp0_valid=rsp1_valid=0, rsp0_out=rsp1_out=0, priority pointer = requester 0.
- Slot free condition: slot_free_i = !rspi_valid | rspi_ready.
- Eligibility: requester i is eligible when reqi_valid & slot_free_i.
- Grant:
  - If exactly one requester is eligible, it is granted.
  - If both are eligible, the requester named by the priority pointer is granted.
  - At most one grant per cycle.
- Ready:
  - reqi_ready = grant_i.
  - reqi_ready is combinational from both valids, both rspi_ready signals and the pointer.
  - Requesters must not make valid depend on ready.
- Pointer update:
  - The pointer moves to the non-granted requester only after a grant made while both were eligible.
  - Otherwise the pointer is unchanged.
- ALU drive:
  - alu_in0/alu_in1/alu_func carry the granted request's fields.
  - With no grant: alu_in0=alu_in1=0, alu_func=4'b0000 (add).
- Latency:
  - A request granted in cycle N gives rspi_valid=1 and rspi_out=alu_out (sampled at N) at cycle N+1.
  - Throughput: 1 result per cycle in total; 1 per cycle per requester when uncontended and the response is drained.
- Response hold:
  - While rspi_valid & !rspi_ready, rspi_out and rspi_valid are stable.
  - No new grant goes to i in that state.
- Same-cycle drain and grant: a slot drained and re-granted in the same cycle is reloaded, so rspi_valid stays 1 with the new value.
- Drain without grant: rspi_valid clears at the next edge.
- Stable input requirement: request fields must be stable while reqi_valid & !reqi_ready. The block does not latch unaccepted requests.
- Reset mid-operation: in-flight results are discarded, the pointer returns to requester 0, and no grants are made in the reset cycle.
- Function codes: passed through unchecked. The ALU returns 0 for undefined codes, and the arbiter returns that 0 as a normal result.

Optional Feature:
ALU_ARB_STATS_EN:
- When defined, adds outputs grant_cnt0, grant_cnt1 and conflict_cnt, each 32 bits.
  - grant_cnt0/grant_cnt1 count grants per requester.
  - conflict_cnt counts cycles where both requesters were eligible.
  - All three saturate at 32'hFFFFFFFF and clear on rst.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - ALU function code constants: ADD 4'b0000, SUB 4'b1000, SLL 4'b0001, SLT 4'b0010, SLTU 4'b0011, XOR 4'b0100, SRL 4'b0101, SRA 4'b1101, OR 4'b0110, AND 4'b0111.
  - Default WIDTH/FUNC_W values.
- Sub-module alu_rsp_slot:
  - A one-entry response register with load, valid/ready and free output.
  - Instantiated twice.
- The arbiter, pointer and optional counters stay in the top level.
- The bench instantiates the real ALU on the alu_* ports.

Test Plan:
- Reset: rst=1 for 2 cycles with both req_valid=1. Required response: no req_ready during reset; after reset rsp0_valid=rsp1_valid=0 and alu_func=0000 when idle.
- Single request: req0 {in0=5, in1=3, func=1000} in cycle N. Required response: req0_ready=1 at N; rsp0_valid=1 and rsp0_out=2 at N+1; rsp1_valid stays 0.
- Contention: after reset, req0 {1,1,ADD} and req1 {10,4,SUB} both held valid. Required response: cycle N grants req0 (rsp0_out=2 at N+1); cycle N+1 grants req1 (rsp1_out=6 at N+2).
- Backpressure: rsp0_ready=0, req0 streams SRA {32'h80000000,4}, req1 streams ADD. Required response: rsp0_out=32'hF8000000 held stable; req0_ready=0 while the slot is full; req1 granted every cycle.
- Back-to-back drain: req0 SLT {32'hFFFFFFFF,1} then SLTU {32'hFFFFFFFF,1} with rsp0_ready=1 throughout. Required response: consecutive rsp0_out values 1 then 0; rsp0_valid never drops between them.
- Reset mid-operation: assert rst while rsp1_valid=1 and rsp1_ready=0. Required response: rsp1_valid=0 next cycle; the next simultaneous contention grants req0 first.
